// File: rtl/booth_radix4_multiplier_if.sv
// booth_radix4_multiplier_if: request/result bundle between a client and the radix-4 Booth multiplier
interface booth_radix4_multiplier_if #(parameter int WIDTH = 8);
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] x_in;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  modport master(output start, signed_mode, y_in, x_in, input busy, done, product);
  modport slave(input start, signed_mode, y_in, x_in, output busy, done, product);
endinterface

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier: sequential radix-4 Booth multiplier, two multiplier bits per cycle, signed or unsigned
module booth_radix4_multiplier #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  booth_radix4_multiplier_if.slave bus
);
  localparam int EW = WIDTH + 2;
  localparam int AW = EW + 2;
  localparam int N = EW / 2;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state;
  logic [AW-1:0] acc;
  logic [EW-1:0] xr, yr;
  logic xm1;
  logic [CW-1:0] cnt;
  logic [2:0] trip;
  logic neg, two, zero;
  logic [AW-1:0] ye, mag, sum;
  logic [AW+EW-1:0] pair;
  logic [EW-1:0] x_ext, y_ext;
  // two guard bits keep +/-2Y of the most negative multiplicand in range
  always_comb begin
    trip = {xr[1:0], xm1};
    neg = trip[2] & !(trip[1] & trip[0]);
    two = trip == 3'b011 || trip == 3'b100;
    zero = trip == 3'b000 || trip == 3'b111;
    ye = {{2{yr[EW-1]}}, yr};
    mag = zero ? '0 : two ? ye << 1 : ye;
    sum = acc + (neg ? ~mag : mag) + {{(AW-1){1'b0}}, neg};
    pair = $signed({sum, xr}) >>> 2;
    x_ext = bus.signed_mode ? {{2{bus.x_in[WIDTH-1]}}, bus.x_in} : {2'b00, bus.x_in};
    y_ext = bus.signed_mode ? {{2{bus.y_in[WIDTH-1]}}, bus.y_in} : {2'b00, bus.y_in};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.product <= '0;
      acc <= '0;
      xr <= '0;
      yr <= '0;
      xm1 <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        ITER: begin
          acc <= pair[AW+EW-1:EW];
          xr <= pair[EW-1:0];
          xm1 <= xr[1];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.product <= pair[2*WIDTH-1:0];
          end
        end
        default: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state <= ITER;
            bus.busy <= 1'b1;
            acc <= '0;
            xr <= x_ext;
            yr <= y_ext;
            xm1 <= 1'b0;
            cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier: directed checks on an 8-bit instance plus model-checked 16-bit sweep
module tb_booth_radix4_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  booth_radix4_multiplier_if #(.WIDTH(8)) b8();
  booth_radix4_multiplier_if #(.WIDTH(16)) b16();
  booth_radix4_multiplier #(.WIDTH(8)) dut8(.clk(clk), .rst(rst), .bus(b8));
  booth_radix4_multiplier #(.WIDTH(16)) dut16(.clk(clk), .rst(rst), .bus(b16));

  task automatic start8(input logic sm, input logic [7:0] y, input logic [7:0] x);
    @(negedge clk);
    b8.start = 1'b1; b8.signed_mode = sm; b8.y_in = y; b8.x_in = x;
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  task automatic wait8(input int l0, output int lat);
    lat = l0;
    while (b8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start16(input logic sm, input logic [15:0] y, input logic [15:0] x);
    @(negedge clk);
    b16.start = 1'b1; b16.signed_mode = sm; b16.y_in = y; b16.x_in = x;
    @(negedge clk);
    b16.start = 1'b0;
  endtask

  task automatic wait16(output int lat);
    lat = 1;
    while (b16.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    b8.start = 0; b8.signed_mode = 0; b8.y_in = 0; b8.x_in = 0;
    b16.start = 0; b16.signed_mode = 0; b16.y_in = 0; b16.x_in = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (b8.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", b8.busy); end
    vectors++; if (b8.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", b8.done); end
    vectors++; if (b8.product !== 16'h0) begin miscompares++; $display("FAIL reset_product got %h want 0000", b8.product); end
    vectors++; if (b16.product !== 32'h0) begin miscompares++; $display("FAIL reset_product16 got %h want 0", b16.product); end
    rst = 1'b0;
  endtask

  task automatic test_most_negative();
    int lat;
    start8(1'b1, 8'h80, 8'h80);
    vectors++; if (b8.busy !== 1'b1) begin miscompares++; $display("FAIL mneg_busy got %b want 1", b8.busy); end
    wait8(1, lat);
    vectors++; if (lat != 6) begin miscompares++; $display("FAIL mneg_latency got %0d want 6", lat); end
    vectors++; if (b8.product !== 16'h4000) begin miscompares++; $display("FAIL mneg_product got %h want 4000", b8.product); end
    vectors++; if (b8.busy !== 1'b0) begin miscompares++; $display("FAIL mneg_busy_at_done got %b want 0", b8.busy); end
    @(negedge clk);
    vectors++; if (b8.done !== 1'b0) begin miscompares++; $display("FAIL mneg_done_pulse got %b want 0", b8.done); end
    vectors++; if (b8.product !== 16'h4000) begin miscompares++; $display("FAIL mneg_hold got %h want 4000", b8.product); end
  endtask

  task automatic test_directed();
    logic sm [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ys [7] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'hC8};
    logic [7:0] xs [7] = '{8'hFF, 8'hFF, 8'h01, 8'h80, 8'hB3, 8'h80, 8'h03};
    logic [15:0] ps [7] = '{16'hFE01, 16'h0001, 16'hFFFF, 16'hC080, 16'h0000, 16'h4000, 16'h0258};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start8(sm[i], ys[i], xs[i]);
      wait8(1, lat);
      vectors++; if (lat != 6) begin miscompares++; $display("FAIL dir%0d_latency got %0d want 6", i, lat); end
      vectors++; if (b8.product !== ps[i]) begin miscompares++; $display("FAIL dir%0d_product got %h want %h", i, b8.product, ps[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    start8(1'b1, 8'h07, 8'hFD);
    @(negedge clk);
    b8.start = 1'b1; b8.signed_mode = 1'b0; b8.y_in = 8'd100; b8.x_in = 8'd100;
    @(negedge clk);
    b8.start = 1'b0;
    wait8(3, lat);
    vectors++; if (lat != 6) begin miscompares++; $display("FAIL ignore_latency got %0d want 6", lat); end
    vectors++; if (b8.product !== 16'hFFEB) begin miscompares++; $display("FAIL ignore_product got %h want ffeb", b8.product); end
    @(negedge clk);
    vectors++; if (b8.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_restart got busy %b want 0", b8.busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start8(1'b1, 8'hFE, 8'h09);
    wait8(1, lat);
    vectors++; if (b8.product !== 16'hFFEE) begin miscompares++; $display("FAIL b2b_first got %h want ffee", b8.product); end
    b8.start = 1'b1; b8.signed_mode = 1'b1; b8.y_in = 8'd3; b8.x_in = 8'd5;
    @(negedge clk);
    b8.start = 1'b0;
    vectors++; if (b8.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_no_gap got busy %b want 1", b8.busy); end
    wait8(1, lat);
    vectors++; if (lat != 6) begin miscompares++; $display("FAIL b2b_latency got %0d want 6", lat); end
    vectors++; if (b8.product !== 16'h000F) begin miscompares++; $display("FAIL b2b_product got %h want 000f", b8.product); end
  endtask

  task automatic test_reset_mid_iter();
    int lat;
    int seen = 0;
    start8(1'b1, 8'h05, 8'h05);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (b8.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", b8.busy); end
    vectors++; if (b8.done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b want 0", b8.done); end
    vectors++; if (b8.product !== 16'h0) begin miscompares++; $display("FAIL midrst_product got %h want 0000", b8.product); end
    repeat (10) begin
      @(negedge clk);
      if (b8.done === 1'b1 || b8.busy === 1'b1) seen = 1;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL midrst_activity got %0d want 0", seen); end
    start8(1'b0, 8'd5, 8'd6);
    wait8(1, lat);
    vectors++; if (lat != 6 || b8.product !== 16'd30) begin miscompares++; $display("FAIL midrst_recover got lat %0d prod %h want 6 001e", lat, b8.product); end
  endtask

  task automatic run16(input logic sm, input logic [15:0] y, input logic [15:0] x);
    longint a, b;
    logic [31:0] exp_p;
    int lat;
    if (sm) begin a = longint'($signed(y)); b = longint'($signed(x)); end
    else begin a = longint'(y); b = longint'(x); end
    exp_p = 32'(a * b);
    start16(sm, y, x);
    wait16(lat);
    vectors++; if (lat != 10) begin miscompares++; $display("FAIL w16_latency sm=%b y=%h x=%h got %0d want 10", sm, y, x, lat); end
    vectors++; if (b16.product !== exp_p) begin miscompares++; $display("FAIL w16_product sm=%b y=%h x=%h got %h want %h", sm, y, x, b16.product, exp_p); end
  endtask

  task automatic test_width16();
    logic [15:0] ext [5] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0001};
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          run16(m[0], ext[i], ext[j]);
    for (int k = 0; k < 1000; k++)
      run16(k[0], 16'($urandom), 16'($urandom));
  endtask

  initial begin
    test_reset();
    test_most_negative();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_iter();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
